// File: rtl/ecc_vec_checker.sv
// Self-checking vector engine for ECC point-multiply cores.
// Streams (Px, Py, k, Rx, Ry) vectors from memory into a DUT and grades the results.
module ecc_vec_checker #(
  parameter int DATA_WIDTH = 256,
  parameter int PATNUM     = 5,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 1000000,
  parameter int GAP        = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop_on_fail,
  output logic                  vec_rd,
  output logic [ADDR_WIDTH-1:0] vec_addr,
  input  logic [DATA_WIDTH-1:0] vec_rdata,
  output logic [DATA_WIDTH-1:0] Px,
  output logic [DATA_WIDTH-1:0] Py,
  output logic [DATA_WIDTH-1:0] k,
  output logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] Rx,
  input  logic [DATA_WIDTH-1:0] Ry,
  input  logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [CNT_WIDTH-1:0]  first_fail_pat,
  output logic [CNT_WIDTH-1:0]  cycles_last,
  output logic [CNT_WIDTH-1:0]  cycles_total
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRIVE, S_WAIT, S_CHECK, S_GAP, S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] PAT_LAST  = CNT_WIDTH'(PATNUM - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = (GAP > 0) ? CNT_WIDTH'(GAP - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [ADDR_WIDTH-1:0] VEC_WORDS = ADDR_WIDTH'(5);

  state_t state, state_next;

  logic [2:0]            load_cnt;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  pat;
  logic [CNT_WIDTH-1:0]  lat_cnt;
  logic [CNT_WIDTH-1:0]  gap_cnt;
  logic                  sof_q;
  logic [DATA_WIDTH-1:0] px_q, py_q, k_q, rx_exp_q, ry_exp_q, rx_q, ry_q;

  logic                  mismatch;
  logic                  timeout_hit;
  logic                  last_pat;
  logic [CNT_WIDTH-1:0]  lat_next;
  logic [CNT_WIDTH:0]    total_sum;

  assign mismatch    = (rx_q != rx_exp_q) || (ry_q != ry_exp_q);
  assign lat_next    = lat_cnt + CNT_WIDTH'(1);
  assign timeout_hit = (lat_next == TIMEOUT_C);
  assign last_pat    = (pat == PAT_LAST);
  assign total_sum   = {1'b0, cycles_total} + {1'b0, lat_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_LOAD;
      S_LOAD:         if (load_cnt == 3'd5) state_next = S_DRIVE;
      S_DRIVE:        state_next = S_WAIT;
      S_WAIT: begin
        if (out_valid)        state_next = S_CHECK;
        else if (timeout_hit) state_next = S_DONE;
      end
      S_CHECK: begin
        if (mismatch && sof_q) state_next = S_DONE;
        else if (last_pat)     state_next = S_DONE;
        else if (GAP == 0)     state_next = S_LOAD;
        else                   state_next = S_GAP;
      end
      S_GAP:          if (gap_cnt == GAP_LAST) state_next = S_LOAD;
      default:        state_next = S_IDLE;
    endcase
  end

  // Operands are forced to zero outside the single request cycle.
  always_comb begin
    vec_rd   = (state == S_LOAD) && (load_cnt < 3'd5);
    vec_addr = vec_rd ? (base_addr + ADDR_WIDTH'(load_cnt)) : '0;
    in_valid = (state == S_DRIVE);
    Px       = in_valid ? px_q : '0;
    Py       = in_valid ? py_q : '0;
    k        = in_valid ? k_q  : '0;
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    pass     = done && (fail_cnt == '0) && !timeout_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt       <= '0;
      base_addr      <= '0;
      pat            <= '0;
      lat_cnt        <= '0;
      gap_cnt        <= '0;
      sof_q          <= 1'b0;
      px_q           <= '0;
      py_q           <= '0;
      k_q            <= '0;
      rx_exp_q       <= '0;
      ry_exp_q       <= '0;
      rx_q           <= '0;
      ry_q           <= '0;
      timeout_err    <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_pat <= ALL_ONES;
      cycles_last    <= '0;
      cycles_total   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            load_cnt       <= '0;
            base_addr      <= '0;
            pat            <= '0;
            sof_q          <= stop_on_fail;
            timeout_err    <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_pat <= ALL_ONES;
            cycles_last    <= '0;
            cycles_total   <= '0;
          end
        end
        // Read data trails its strobe by one cycle, so word i lands at load_cnt i+1.
        S_LOAD: begin
          load_cnt <= load_cnt + 3'd1;
          case (load_cnt)
            3'd1:    px_q     <= vec_rdata;
            3'd2:    py_q     <= vec_rdata;
            3'd3:    k_q      <= vec_rdata;
            3'd4:    rx_exp_q <= vec_rdata;
            3'd5:    ry_exp_q <= vec_rdata;
            default: ;
          endcase
        end
        S_DRIVE: lat_cnt <= '0;
        S_WAIT: begin
          if (out_valid) begin
            rx_q         <= Rx;
            ry_q         <= Ry;
            cycles_last  <= lat_next;
            cycles_total <= total_sum[CNT_WIDTH] ? ALL_ONES : total_sum[CNT_WIDTH-1:0];
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            fail_cnt    <= fail_cnt + CNT_WIDTH'(1);
            if (first_fail_pat == ALL_ONES) first_fail_pat <= pat;
          end else begin
            lat_cnt <= lat_next;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_cnt <= fail_cnt + CNT_WIDTH'(1);
            if (first_fail_pat == ALL_ONES) first_fail_pat <= pat;
          end else begin
            pass_cnt <= pass_cnt + CNT_WIDTH'(1);
          end
          if (!(mismatch && sof_q) && !last_pat) begin
            pat       <= pat + CNT_WIDTH'(1);
            base_addr <= base_addr + VEC_WORDS;
            load_cnt  <= '0;
            gap_cnt   <= '0;
          end
        end
        S_GAP: gap_cnt <= gap_cnt + CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_vec_checker.sv
// Directed bench for ecc_vec_checker with a vector ROM and a stub point-multiply core
// that returns Rx = Px ^ k, Ry = Py + 1 after a programmable latency.
module tb_ecc_vec_checker;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 32;
  localparam logic [CW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop_on_fail;
  logic          vec_rd;
  logic [AW-1:0] vec_addr;
  logic [DW-1:0] vec_rdata;
  logic [DW-1:0] Px, Py, k;
  logic          in_valid;
  logic [DW-1:0] Rx, Ry;
  logic          out_valid;
  logic          busy, done, pass, timeout_err;
  logic [CW-1:0] pass_cnt, fail_cnt, first_fail_pat, cycles_last, cycles_total;

  ecc_vec_checker #(
    .DATA_WIDTH(DW), .PATNUM(5), .ADDR_WIDTH(AW),
    .TIMEOUT(100), .GAP(0), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
    .vec_rd(vec_rd), .vec_addr(vec_addr), .vec_rdata(vec_rdata),
    .Px(Px), .Py(Py), .k(k), .in_valid(in_valid),
    .Rx(Rx), .Ry(Ry), .out_valid(out_valid),
    .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_pat(first_fail_pat),
    .cycles_last(cycles_last), .cycles_total(cycles_total)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector ROM: one-cycle read latency
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (vec_rd) vec_rdata <= mem[vec_addr];

  // Stub core
  int            stub_lat = 7;
  logic          stub_en = 1'b1;
  int            st_cnt;
  logic [DW-1:0] st_rx, st_ry;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt <= 0; st_rx <= '0; st_ry <= '0;
    end else if (in_valid && stub_en) begin
      st_cnt <= stub_lat; st_rx <= Px ^ k; st_ry <= Py + 32'd1;
    end else if (st_cnt != 0) begin
      st_cnt <= st_cnt - 1;
    end
  end
  assign out_valid = (st_cnt == 1);
  assign Rx = st_rx;
  assign Ry = st_ry;

  // Monitor: request/read activity and operand leakage outside in_valid
  int iv_cnt = 0, rd_cnt = 0, leak_cnt = 0, iv_cyc_last = 0, iv_cyc_prev = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid) begin
        iv_cnt <= iv_cnt + 1; iv_cyc_prev <= iv_cyc_last; iv_cyc_last <= cyc;
      end
      if (vec_rd) rd_cnt <= rd_cnt + 1;
      if (!in_valid && ((Px | Py | k) != '0)) leak_cnt <= leak_cnt + 1;
    end
  end

  int start_cyc;
  task automatic pulse_start(input logic sof);
    @(negedge clk);
    start = 1'b1; stop_on_fail = sof; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; stop_on_fail = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int at_cyc);
    ok = 1'b0; at_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; at_cyc = cyc; break; end
    end
  endtask

  task automatic load_vectors();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]  = 32'h0000_0011; mem[1]  = 32'h0000_0100; mem[2]  = 32'h0000_0003;
    mem[3]  = 32'h0000_0012; mem[4]  = 32'h0000_0101;
    mem[5]  = 32'hA5A5_0000; mem[6]  = 32'hFFFF_FFFF; mem[7]  = 32'h0000_5A5A;
    mem[8]  = 32'hA5A5_5A5A; mem[9]  = 32'h0000_0000;
    mem[10] = 32'h1234_5678; mem[11] = 32'h0000_0010; mem[12] = 32'hFFFF_0000;
    mem[13] = 32'hEDCB_5678; mem[14] = 32'h0000_0011;
    mem[15] = 32'hDEAD_BEEF; mem[16] = 32'h7FFF_FFFF; mem[17] = 32'hDEAD_BEEF;
    mem[18] = 32'h0000_0000; mem[19] = 32'h8000_0000;
    mem[20] = 32'h0000_0000; mem[21] = 32'hCAFE_0000; mem[22] = 32'h8000_0001;
    mem[23] = 32'h8000_0001; mem[24] = 32'hCAFE_0001;
  endtask

  task automatic check_idle_values(input string tag);
    vec_cnt++;
    if ({busy, done, pass, timeout_err, in_valid, vec_rd} !== 6'b0) begin
      err_cnt++;
      $display("[TB] FAIL %s flags: got busy=%b done=%b pass=%b tmo=%b iv=%b rd=%b, want all 0",
               tag, busy, done, pass, timeout_err, in_valid, vec_rd);
    end
    vec_cnt++;
    if ({pass_cnt, fail_cnt, cycles_last, cycles_total} !== '0) begin
      err_cnt++;
      $display("[TB] FAIL %s counters: got pass=%0d fail=%0d last=%0d total=%0d, want 0",
               tag, pass_cnt, fail_cnt, cycles_last, cycles_total);
    end
    vec_cnt++;
    if (first_fail_pat !== ONES || vec_addr !== '0 || Px !== '0) begin
      err_cnt++;
      $display("[TB] FAIL %s first_fail/addr/Px: got %h/%h/%h, want ffffffff/00/0",
               tag, first_fail_pat, vec_addr, Px);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop_on_fail = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    bit ok; int dc; int iv0, rd0, lk0;
    stub_lat = 7; stub_en = 1'b1;
    iv0 = iv_cnt; rd0 = rd_cnt; lk0 = leak_cnt;
    pulse_start(1'b0);
    wait_done(500, ok, dc);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL all_pass done: got timeout, want done"); end
    @(negedge clk);
    vec_cnt++;
    if (pass !== 1'b1 || pass_cnt !== 5 || fail_cnt !== 0) begin
      err_cnt++;
      $display("[TB] FAIL all_pass result: got pass=%b p=%0d f=%0d, want 1/5/0", pass, pass_cnt, fail_cnt);
    end
    vec_cnt++;
    if (cycles_last !== 7 || cycles_total !== 35) begin
      err_cnt++;
      $display("[TB] FAIL all_pass latency: got last=%0d total=%0d, want 7/35", cycles_last, cycles_total);
    end
    vec_cnt++;
    if (iv_cnt - iv0 !== 5 || rd_cnt - rd0 !== 25 || leak_cnt - lk0 !== 0) begin
      err_cnt++;
      $display("[TB] FAIL all_pass traffic: got iv=%0d rd=%0d leak=%0d, want 5/25/0",
               iv_cnt - iv0, rd_cnt - rd0, leak_cnt - lk0);
    end
    vec_cnt++;
    if (first_fail_pat !== ONES || timeout_err !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL all_pass status: got ff=%h tmo=%b busy=%b, want ffffffff/0/0",
               first_fail_pat, timeout_err, busy);
    end
  endtask

  task automatic test_fail_continue();
    bit ok; int dc; int iv0;
    mem[14] = 32'h0000_0012;
    iv0 = iv_cnt;
    pulse_start(1'b0);
    wait_done(500, ok, dc);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL fail_continue done: got timeout, want done"); end
    vec_cnt++;
    if (pass_cnt !== 4 || fail_cnt !== 1 || first_fail_pat !== 2 || pass !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL fail_continue result: got p=%0d f=%0d ff=%0d pass=%b, want 4/1/2/0",
               pass_cnt, fail_cnt, first_fail_pat, pass);
    end
    vec_cnt++;
    if (iv_cnt - iv0 !== 5) begin
      err_cnt++;
      $display("[TB] FAIL fail_continue in_valid: got %0d, want 5", iv_cnt - iv0);
    end
  endtask

  task automatic test_stop_on_fail();
    bit ok; int dc; int iv0, rd0;
    iv0 = iv_cnt; rd0 = rd_cnt;
    pulse_start(1'b1);
    wait_done(500, ok, dc);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL stop_on_fail done: got timeout, want done"); end
    repeat (20) @(negedge clk);
    vec_cnt++;
    if (pass_cnt !== 2 || fail_cnt !== 1 || first_fail_pat !== 2 || pass !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL stop_on_fail result: got p=%0d f=%0d ff=%0d pass=%b, want 2/1/2/0",
               pass_cnt, fail_cnt, first_fail_pat, pass);
    end
    vec_cnt++;
    if (iv_cnt - iv0 !== 3 || rd_cnt - rd0 !== 15) begin
      err_cnt++;
      $display("[TB] FAIL stop_on_fail traffic: got iv=%0d rd=%0d, want 3/15", iv_cnt - iv0, rd_cnt - rd0);
    end
    mem[14] = 32'h0000_0011;
  endtask

  task automatic test_timeout();
    bit ok; int dc; int iv0;
    stub_en = 1'b0;
    iv0 = iv_cnt;
    pulse_start(1'b0);
    wait_done(300, ok, dc);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL timeout done: got no done, want done"); end
    @(negedge clk);
    vec_cnt++;
    if (timeout_err !== 1'b1 || fail_cnt !== 1 || first_fail_pat !== 0 || pass !== 1'b0 || pass_cnt !== 0) begin
      err_cnt++;
      $display("[TB] FAIL timeout result: got tmo=%b f=%0d ff=%0d pass=%b p=%0d, want 1/1/0/0/0",
               timeout_err, fail_cnt, first_fail_pat, pass, pass_cnt);
    end
    vec_cnt++;
    if (iv_cnt - iv0 !== 1 || dc - iv_cyc_last !== 101) begin
      err_cnt++;
      $display("[TB] FAIL timeout timing: got iv=%0d done-drive=%0d, want 1/101",
               iv_cnt - iv0, dc - iv_cyc_last);
    end
    stub_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok; int dc; int iv0, s0;
    stub_lat = 1;
    iv0 = iv_cnt;
    pulse_start(1'b0);
    s0 = start_cyc;
    repeat (18) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, ok, dc);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL back_to_back done: got timeout, want done"); end
    @(negedge clk);
    vec_cnt++;
    if (pass !== 1'b1 || pass_cnt !== 5 || cycles_last !== 1 || cycles_total !== 5) begin
      err_cnt++;
      $display("[TB] FAIL back_to_back result: got pass=%b p=%0d last=%0d total=%0d, want 1/5/1/5",
               pass, pass_cnt, cycles_last, cycles_total);
    end
    vec_cnt++;
    if (iv_cnt - iv0 !== 5 || iv_cyc_last - iv_cyc_prev !== 9 || dc - s0 !== 46) begin
      err_cnt++;
      $display("[TB] FAIL back_to_back timing: got iv=%0d spacing=%0d run=%0d, want 5/9/46",
               iv_cnt - iv0, iv_cyc_last - iv_cyc_prev, dc - s0);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok; int dc; int iv0;
    stub_lat = 7;
    iv0 = iv_cnt;
    pulse_start(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (iv_cnt - iv0 >= 4) begin ok = 1'b1; break; end
    end
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL reset_mid_run reach: got %0d in_valid, want 4", iv_cnt - iv0); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_values("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    iv0 = iv_cnt;
    pulse_start(1'b0);
    wait_done(500, ok, dc);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("[TB] FAIL reset_rerun done: got timeout, want done"); end
    vec_cnt++;
    if (pass !== 1'b1 || pass_cnt !== 5 || fail_cnt !== 0 || iv_cnt - iv0 !== 5) begin
      err_cnt++;
      $display("[TB] FAIL reset_rerun result: got pass=%b p=%0d f=%0d iv=%0d, want 1/5/0/5",
               pass, pass_cnt, fail_cnt, iv_cnt - iv0);
    end
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_all_pass();
    test_fail_continue();
    test_stop_on_fail();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ecc_vec_checker.md
Name: ecc_vec_checker

Overview:
- Synthesizable, parametrised self-checking pattern engine for ECC point-multiply cores (R = k·P).
- Fetches (Px, Py, k, Rx, Ry) vectors from a word-addressed vector memory and drives one request per vector on a single-cycle in_valid pulse.
- Waits for out_valid with a timeout, then compares Rx/Ry, counts pass/fail and latency.
- Sits between a vector ROM/BRAM and the DUT, for FPGA bring-up and regression.

Parameters:
- DATA_WIDTH, 256: width of coordinates, scalar and vector-memory words.
- PATNUM, 5: number of vectors per run.
- ADDR_WIDTH, 12: vector-memory address width. PATNUM*5 must be ≤ 2^ADDR_WIDTH.
- TIMEOUT, 1000000: maximum cycles to wait for out_valid.
- GAP, 1: idle cycles between a check and the next fetch. 0 is allowed.
- CNT_WIDTH, 32: width of the cycle and pattern counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a run. Ignored unless in IDLE or DONE.
- stop_on_fail  in  1  sampled at start. When 1, a run aborts on the first mismatch.
- vec_rd  out  1  vector-memory read strobe
- vec_addr  out  ADDR_WIDTH  read address
- vec_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after vec_rd
- Px, Py, k  out  DATA_WIDTH  DUT operands. Hold 0 whenever in_valid=0.
- in_valid  out  1  DUT request strobe, one cycle per vector
- Rx, Ry  in  DATA_WIDTH  DUT result
- out_valid  in  1  DUT result strobe
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE, until the next start
- pass  out  1  done & (fail_cnt==0) & ~timeout_err
- timeout_err  out  1  sticky per run
- pass_cnt, fail_cnt  out  CNT_WIDTH  per-run counters
- first_fail_pat  out  CNT_WIDTH  index of the first failing vector. All-ones if none.
- cycles_last  out  CNT_WIDTH  latency of the most recent vector
- cycles_total  out  CNT_WIDTH  sum of latencies, saturating at all-ones

Behaviour:
- Reset values: all outputs 0, except first_fail_pat = all-ones. State = IDLE.
- Reset asserted mid-run aborts immediately. No partial results are retained.
- Vector layout: vector p occupies words p*5+0..4, in the order Px, Py, k, Rx, Ry.
- start, accepted in IDLE or DONE:
  - clears counters, timeout_err and done; sets first_fail_pat = all-ones;
  - sets p = 0; latches stop_on_fail; enters LOAD.
- LOAD:
  - vec_rd=1 on 5 consecutive cycles, addresses p*5+0..4.
  - Each word is captured one cycle after its read.
  - The state lasts 6 cycles, then goes to DRIVE.
- DRIVE:
  - Exactly one cycle with in_valid=1 and Px/Py/k = the captured words.
  - The latency counter is cleared to 0. Next state: WAIT.
- WAIT:
  - The counter increments every cycle.
  - Latency = number of rising edges from the DRIVE edge to the edge at which out_valid is sampled high. A result one cycle after in_valid gives latency 1.
  - out_valid high during LOAD or DRIVE is ignored.
  - On out_valid: Rx/Ry are registered on that edge; cycles_last = latency; cycles_total += latency (saturating). Next state: CHECK.
  - If the counter reaches TIMEOUT without out_valid: timeout_err=1, fail_cnt+1, first_fail_pat updated if still all-ones, then DONE. A timeout always aborts, regardless of stop_on_fail.
- CHECK (1 cycle): compare the captured Rx/Ry against the expected words, full width.
  - Match: pass_cnt+1.
  - Mismatch: fail_cnt+1; first_fail_pat=p if still all-ones; if stop_on_fail latched, go to DONE.
  - Otherwise:
    - if p == PATNUM-1, go to DONE;
    - else p+1, then GAP (GAP cycles; skipped when GAP=0), then LOAD.
- DONE: busy=0, done=1. A new start restarts from vector 0.
- Simultaneous start and out_valid in DONE: start wins; out_valid is ignored.
- Counters never wrap in a run: PATNUM < 2^CNT_WIDTH.

Test Plan:
- Stub DUT returning Rx=Px^k, Ry=Py+1 after 7 cycles; 5 matching vectors; start -> in_valid pulses 5 times; pass=1, pass_cnt=5, fail_cnt=0, cycles_last=7, cycles_total=35.
- Vector 2 Ry expected corrupted by +1, stop_on_fail=0 -> run completes; pass_cnt=4, fail_cnt=1, first_fail_pat=2, pass=0.
- Same corruption with stop_on_fail=1 -> done after the 3rd in_valid; pass_cnt=2, fail_cnt=1, first_fail_pat=2, and no 4th vec_rd burst.
- Stub never asserts out_valid, TIMEOUT=100 -> timeout_err=1 at cycle 100 of WAIT; done=1, fail_cnt=1, first_fail_pat=0.
- Stub latency 1 with GAP=0, then a start pulse while busy -> each vector takes 6+1+1+1=9 cycles; the mid-run start has no effect; cycles_last=1.
- rst_n pulsed low during WAIT of vector 3, then start -> all outputs at reset values; the rerun passes from vector 0 with pass_cnt=5.
